// File: rtl/pe_out_collector.sv
// ---------------------------------------------------------------------------
// pe_out_collector
//
// Gathers one result word per PE lane into a frame. The frame is then sent,
// lane 0 first, on a single valid/ready stream. Every frame is exactly PE_NUM
// beats long. A lane that produced no result is sent as a zero word.
//
// While a frame is being sent, new results are parked in a one-deep pending
// slot per lane. When the last beat is accepted, the pending words become the
// next frame.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset (0 = reset)
//   flush       one-cycle request to send a partially filled frame
//   pe_out_v    per-lane result-valid pulse            [PE_NUM]
//   pe_out      packed per-lane result words           [PE_NUM*DATA_WIDTH*2]
//   dout_ready  downstream accept
//   dout_v      output word valid
//   dout        output word (complex I/Q pair)         [DATA_WIDTH*2]
//   dout_lane   source lane of the current word        [LANE_W]
//   dout_last   final word of the frame
//   busy        frame is being sent
//   overflow    sticky: a result word was overwritten before it was sent
// ---------------------------------------------------------------------------
module pe_out_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int PE_NUM     = 8,
    parameter int LANE_W     = $clog2(PE_NUM)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [PE_NUM-1:0]              pe_out_v,
    input  logic [PE_NUM*DATA_WIDTH*2-1:0] pe_out,
    input  logic                           dout_ready,
    output logic                           dout_v,
    output logic [DATA_WIDTH*2-1:0]        dout,
    output logic [LANE_W-1:0]              dout_lane,
    output logic                           dout_last,
    output logic                           busy,
    output logic                           overflow
);

    localparam int                WORD_W    = DATA_WIDTH * 2;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PE_NUM - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [LANE_W-1:0] idx_reg, idx_next;

    // cap holds the frame being collected or sent.
    // pend holds results that arrive while a frame is being sent.
    logic [WORD_W-1:0] cap_reg  [PE_NUM];
    logic [WORD_W-1:0] cap_next [PE_NUM];
    logic [WORD_W-1:0] pend_reg [PE_NUM];
    logic [WORD_W-1:0] pend_next[PE_NUM];
    logic [WORD_W-1:0] lane_word[PE_NUM];

    logic [PE_NUM-1:0] full_reg, full_next;
    logic [PE_NUM-1:0] pv_reg, pv_next;
    logic [PE_NUM-1:0] lane_ovf;
    logic              overflow_reg, overflow_next;

    logic              sending;
    logic              accept;
    logic              turnover;
    logic              launch;

    assign sending  = (state_reg == SEND);
    assign accept   = sending && dout_ready;
    // The last-beat acceptance edge is also the frame turnover edge.
    assign turnover = accept && (idx_reg == LAST_LANE);

    // Start sending once the registered frame is complete. A flush also
    // starts sending if any lane holds a word or is being captured this
    // cycle. A flush with nothing to send is dropped.
    assign launch = (state_reg == COLLECT) &&
                    ((&full_reg) || (flush && ((|full_reg) || (|pe_out_v))));

    // -----------------------------------------------------------------------
    // Per-lane storage update
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < PE_NUM; gi++) begin : g_lane
            assign lane_word[gi] = pe_out[gi*WORD_W +: WORD_W];

            // cap is written by captures in COLLECT. On turnover it is
            // reloaded from pend, but a word arriving on that same edge wins.
            // cap is left untouched during the rest of SEND.
            assign cap_next[gi] =
                (!sending && pe_out_v[gi]) ? lane_word[gi] :
                turnover ? (pe_out_v[gi] ? lane_word[gi] : pend_reg[gi]) :
                cap_reg[gi];

            assign full_next[gi] =
                !sending ? (full_reg[gi] | pe_out_v[gi]) :
                turnover ? (pv_reg[gi] | pe_out_v[gi]) :
                full_reg[gi];

            assign pend_next[gi] =
                (sending && !turnover && pe_out_v[gi]) ? lane_word[gi] : pend_reg[gi];

            // pend is drained into cap on turnover. pend is never used
            // outside SEND.
            assign pv_next[gi] = sending && !turnover && (pv_reg[gi] | pe_out_v[gi]);

            // A word is lost when it lands on an occupied slot. The slot is
            // cap in COLLECT and pend in SEND, including the turnover edge.
            assign lane_ovf[gi] = pe_out_v[gi] & (sending ? pv_reg[gi] : full_reg[gi]);
        end
    endgenerate

    assign overflow_next = overflow_reg | (|lane_ovf);

    // -----------------------------------------------------------------------
    // Sequencer: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            COLLECT: begin
                if (launch) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_reg == LAST_LANE) begin
                        idx_next   = '0;
                        state_next = COLLECT;
                    end else begin
                        idx_next = idx_reg + LANE_W'(1);
                    end
                end
            end
            default: begin
                state_next = COLLECT;
                idx_next   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= COLLECT;
            idx_reg      <= '0;
            full_reg     <= '0;
            pv_reg       <= '0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < PE_NUM; i++) begin
                cap_reg[i]  <= '0;
                pend_reg[i] <= '0;
            end
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            full_reg     <= full_next;
            pv_reg       <= pv_next;
            overflow_reg <= overflow_next;
            cap_reg      <= cap_next;
            pend_reg     <= pend_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // All outputs decode registered state only. When reset clears those
    // registers, the outputs drop at once without waiting for a clock edge.
    // An empty lane reads as zero.
    assign dout_v    = sending;
    assign busy      = sending;
    assign dout      = (sending && full_reg[idx_reg]) ? cap_reg[idx_reg] : '0;
    assign dout_lane = idx_reg;
    assign dout_last = sending && (idx_reg == LAST_LANE);
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pe_out_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_out_collector
//
// Drives pe_out_collector (PE_NUM=4, DATA_WIDTH=16) with directed steps, then
// with random traffic. The reference model works at frame level:
//   - a per-lane "have" set collects words;
//   - a frame launch pushes PE_NUM expected beats onto a queue;
//   - each accepted beat pops one entry from that queue.
// Outputs are compared one time unit after every rising edge.
// ---------------------------------------------------------------------------
module tb_pe_out_collector;

    localparam int DW = 16;
    localparam int PN = 4;
    localparam int LW = 2;
    localparam int WW = DW * 2;

    logic            clk        = 1'b0;
    logic            rst        = 1'b0;
    logic            flush      = 1'b0;
    logic [PN-1:0]   pe_out_v   = '0;
    logic [PN*WW-1:0] pe_out    = '0;
    logic            dout_ready = 1'b0;
    logic            dout_v;
    logic [WW-1:0]   dout;
    logic [LW-1:0]   dout_lane;
    logic            dout_last;
    logic            busy;
    logic            overflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit              m_sending;
    bit              m_ovf;
    bit              m_have [PN];
    logic [WW-1:0]   m_word [PN];
    logic [WW-1:0]   exp_data[$];
    int              exp_lane[$];
    bit              exp_last[$];

    pe_out_collector #(
        .DATA_WIDTH(DW),
        .PE_NUM    (PN),
        .LANE_W    (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .pe_out_v  (pe_out_v),
        .pe_out    (pe_out),
        .dout_ready(dout_ready),
        .dout_v    (dout_v),
        .dout      (dout),
        .dout_lane (dout_lane),
        .dout_last (dout_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [PN*WW-1:0] pack4(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                               input logic [WW-1:0] c, input logic [WW-1:0] d);
        return {d, c, b, a};
    endfunction

    task automatic model_reset();
        m_sending = 1'b0;
        m_ovf     = 1'b0;
        for (int i = 0; i < PN; i++) begin
            m_have[i] = 1'b0;
            m_word[i] = '0;
        end
        exp_data.delete();
        exp_lane.delete();
        exp_last.delete();
    endtask

    // Store arriving words. Landing on a lane that already holds an unsent
    // word loses that word.
    task automatic model_capture(input logic [PN-1:0] v, input logic [PN*WW-1:0] w);
        for (int i = 0; i < PN; i++) begin
            if (v[i]) begin
                if (m_have[i]) m_ovf = 1'b1;
                m_have[i] = 1'b1;
                m_word[i] = w[i*WW +: WW];
            end
        end
    endtask

    // Apply one clock edge to the model, given the inputs seen at that edge.
    task automatic model_edge(input logic [PN-1:0] v, input logic [PN*WW-1:0] w,
                              input logic f, input logic r);
        bit all_have;
        bit any_have;
        bit go;
        if (!m_sending) begin
            all_have = 1'b1;
            any_have = 1'b0;
            for (int i = 0; i < PN; i++) begin
                all_have &= m_have[i];
                any_have |= m_have[i];
            end
            go = all_have || (f && (any_have || (v != '0)));
            model_capture(v, w);
            if (go) begin
                for (int i = 0; i < PN; i++) begin
                    exp_data.push_back(m_have[i] ? m_word[i] : '0);
                    exp_lane.push_back(i);
                    exp_last.push_back(i == PN - 1);
                    m_have[i] = 1'b0;
                end
                m_sending = 1'b1;
            end
        end else if (r) begin
            $display("beat lane=%0d data=%h last=%0d", exp_lane[0], exp_data[0], exp_last[0]);
            exp_data.delete(0);
            exp_lane.delete(0);
            exp_last.delete(0);
            model_capture(v, w);
            if (exp_data.size() == 0) m_sending = 1'b0;
        end else begin
            model_capture(v, w);
        end
    endtask

    task automatic check_outputs();
        chk("dout_v", 32'(dout_v), 32'(m_sending));
        chk("busy", 32'(busy), 32'(m_sending));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_sending) begin
            chk("dout", dout, exp_data[0]);
            chk("dout_lane", 32'(dout_lane), 32'(exp_lane[0]));
            chk("dout_last", 32'(dout_last), 32'(exp_last[0]));
        end
    endtask

    // One clock cycle: check the current outputs, drive the inputs, take the
    // edge, then advance the model.
    task automatic step(input logic [PN-1:0] v, input logic [PN*WW-1:0] w,
                        input logic f, input logic r);
        check_outputs();
        pe_out_v   = v;
        pe_out     = w;
        flush      = f;
        dout_ready = r;
        @(posedge clk);
        model_edge(v, w, f, r);
        #1;
        pe_out_v = '0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n, input logic r);
        for (int k = 0; k < n; k++) step('0, '0, 1'b0, r);
    endtask

    initial begin
        logic [PN*WW-1:0] w;
        model_reset();

        // Reset state, checked before any clock edge.
        #1;
        chk("rst_dout_v", 32'(dout_v), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dout", dout, 32'd0);
        chk("rst_lane", 32'(dout_lane), 32'd0);
        chk("rst_last", 32'(dout_last), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: lanes filled on consecutive cycles.
        for (int i = 0; i < PN; i++) begin
            w = '0;
            w[i*WW +: WW] = 32'h1111_0000 + 32'(i);
            step(PN'(1 << i), w, 1'b0, 1'b1);
        end
        idle(6, 1'b1);

        // 2: full frame with a 5-cycle stall, then ready toggling.
        step('1, pack4($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b1);
        idle(6, 1'b0);
        for (int k = 0; k < 8; k++) step('0, '0, 1'b0, (k % 2) == 0);
        idle(4, 1'b1);

        // 3: partial frame via flush, then a flush with nothing captured.
        step(4'b0001, pack4(32'hA0A0_A0A0, '0, '0, '0), 1'b0, 1'b1);
        step(4'b0100, pack4('0, '0, 32'hC2C2_C2C2, '0), 1'b0, 1'b1);
        step('0, '0, 1'b1, 1'b1);
        idle(6, 1'b1);
        step('0, '0, 1'b1, 1'b1);
        idle(3, 1'b1);

        // 4: a capture during SEND is held for the next frame; a second
        //    capture on the same lane during SEND sets overflow.
        step('1, pack4($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b1);
        idle(1, 1'b0);
        step(4'b0010, pack4('0, 32'hBEEF_0001, '0, '0), 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(5, 1'b1);
        step('0, '0, 1'b1, 1'b1);
        idle(6, 1'b1);
        step('1, pack4($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b1);
        idle(1, 1'b0);
        step(4'b0010, pack4('0, 32'hBEEF_0002, '0, '0), 1'b0, 1'b0);
        step(4'b0010, pack4('0, 32'hBEEF_0003, '0, '0), 1'b0, 1'b0);
        idle(9, 1'b1);

        // 5: asynchronous reset while beat 2 is being presented.
        step('1, pack4($urandom, $urandom, $urandom, $urandom), 1'b0, 1'b1);
        idle(3, 1'b1);
        check_outputs();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_dout_v", 32'(dout_v), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dout", dout, 32'd0);
        chk("arst_lane", 32'(dout_lane), 32'd0);
        chk("arst_last", 32'(dout_last), 32'd0);
        chk("arst_overflow", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4, 1'b1);
        step(4'b0001, pack4(32'h5A5A_0000, '0, '0, '0), 1'b1, 1'b1);
        idle(6, 1'b1);

        // 6: all lanes together with flush -> exactly one frame.
        step('1, pack4(32'h6000_0000, 32'h6000_0001, 32'h6000_0002, 32'h6000_0003), 1'b1, 1'b1);
        idle(6, 1'b1);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) == 0) ? PN'($urandom) : '0,
                 pack4($urandom, $urandom, $urandom, $urandom),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0);
        end
        idle(10, 1'b1);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_out_collector.md
Name: pe_out_collector

Overview:
Output-side counterpart of the PE array input distributor. The distributor fans one serial input stream out to PE_NUM processing elements. This block gathers the per-PE result words from all lanes into one frame and serializes the frame onto a single valid/ready output stream, lane 0 first. It sits between the PE array result ports and the overlay output port, and it buffers results that arrive while a frame is still being sent.

Parameters:
DATA_WIDTH, 16, half-word width; one stream word is DATA_WIDTH*2 bits (complex I/Q pair).
PE_NUM, 8, number of PE result lanes; must be at least 2.
LANE_W, clog2(PE_NUM), width of the lane index.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  reset, asynchronous, active-low (0 = reset).
flush  in  1  single-cycle request to send a partially filled frame.
pe_out_v  in  PE_NUM  per-lane result-valid pulse.
pe_out  in  PE_NUM*DATA_WIDTH*2  packed result words; lane i is at bits [(i+1)*DATA_WIDTH*2-1 : i*DATA_WIDTH*2].
dout_ready  in  1  downstream accept.
dout_v  out  1  output word valid.
dout  out  DATA_WIDTH*2  output word.
dout_lane  out  LANE_W  source lane of the current word.
dout_last  out  1  high on the final word of a frame.
busy  out  1  high while in SEND.
overflow  out  1  sticky; a result word was lost.

Behaviour:
- Storage:
  - cap[PE_NUM] with flags full[PE_NUM]: the frame being collected or sent.
  - pend[PE_NUM] with flags pv[PE_NUM]: one-deep holding slot per lane, used during SEND.
  - idx (LANE_W bits): index of the word currently presented.
- Reset (rst=0, takes effect asynchronously):
  - state=COLLECT, idx=0, all flags cleared, overflow=0.
  - Outputs go to 0 immediately: dout_v, dout, dout_lane, dout_last, busy.
  - Data registers may also be cleared to 0.
- COLLECT state:
  - pe_out_v[i]=1 writes cap[i] and sets full[i].
  - If full[i] was already set, the new word overwrites cap[i] and overflow is set.
- COLLECT to SEND: taken at the edge after the registered full[] vector is all ones, or after a flush cycle in which at least one full[] bit (registered or being set that cycle) is high.
  - A flush with no lane full and no lane being captured is ignored.
  - A flush issued while in SEND is ignored.
- Latency: the earliest dout_v is one cycle after the capture edge that completes the frame.
- SEND state:
  - dout_v=1; dout = cap[idx] if full[idx], else 0; dout_lane=idx; dout_last=(idx==PE_NUM-1).
  - Every lane is sent, so each frame is always exactly PE_NUM beats.
  - A beat is accepted on any edge with dout_v && dout_ready. On acceptance idx increments.
  - While dout_ready=0, dout, dout_lane and dout_last stay stable.
  - Acceptance of the last beat: idx wraps to 0, state returns to COLLECT, and busy/dout_v go to 0 the next cycle.
- Captures during SEND:
  - pe_out_v[i] writes pend[i] and sets pv[i]; cap is never modified during SEND.
  - If pv[i] is already set, pend[i] is overwritten and overflow is set.
- Frame turnover, on the last-beat acceptance edge:
  - cap[i] = pend[i] and full[i] = pv[i]; all pv cleared.
  - A pe_out_v[i] pulse on that same edge goes straight into cap[i]. If pv[i] was also set, the pe_out_v word wins and overflow is set.
  - If all lanes end up full after turnover, the next frame starts sending after one COLLECT cycle.
- overflow stays high until reset.
- busy = (state==SEND).

Test Plan (PE_NUM=4, DATA_WIDTH=16, dout_ready=1 unless stated):
1. Pulse lanes 0..3 on consecutive cycles with 0x11110000+i → dout_v rises one cycle after the lane 3 capture. Four beats 0x11110000..0x11110003 on lanes 0..3, dout_last only on beat 4, busy for exactly 4 cycles.
2. Fill all lanes, hold dout_ready=0 for 5 cycles, then toggle it 1/0 → lane 0 word held stable during the stall. Four beats in lane order, no duplicates or drops.
3. Capture lanes 0 (0xA0A0A0A0) and 2 (0xC2C2C2C2), then flush → beats 0xA0A0A0A0, 0, 0xC2C2C2C2, 0; last on lane 3; all flags empty afterwards. A flush with nothing captured produces no dout_v.
4. In SEND with ready=0, pulse lane 1 with 0xBEEF0001 → overflow stays 0. After the frame, a flush sends 0xBEEF0001 on lane 1. A second lane-1 pulse during a later SEND sets overflow=1, and it holds 1 until reset.
5. Assert rst=0 mid-SEND at beat 2 → dout_v/busy drop to 0 without waiting for a clock edge. After release, no output appears until a new frame is captured, and the next frame starts at lane 0.
6. All four lanes pulse in one cycle together with flush → exactly one 4-beat frame and overflow=0.
